clock24_display: RTL and testbench

Multiplexed 4-digit 7-segment display driver for the 24-hour time counter: consumes the BCD digit buses `min1`, `min10`, `hour1`, `hour10` and scans them onto a common-anode display. Each scan frame starts by snapshotting all four digits, so a minute/hour rollover can never show a torn value. It sits between the time-keeping counter and the board display pins.

---
 rtl/clock24_display.sv | 131 +++++++++++++
 tb/tb_clock24_display.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/clock24_display.sv
// Multiplexed 4-digit common-anode 7-segment driver for a 24-hour clock, with a per-frame digit snapshot.
// Optional leading-zero blanking of the hours-tens digit: define CLOCK24_DISPLAY_LZB_EN.
module clock24_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] min1,
  input  logic [2:0] min10,
  input  logic [3:0] hour1,
  input  logic [1:0] hour10,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame
);

  localparam int CW = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    s_m1_q, s_m1_d;
  logic [2:0]    s_m10_q, s_m10_d;
  logic [3:0]    s_h1_q, s_h1_d;
  logic [1:0]    s_h10_q, s_h10_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_q, frame_d;

  logic          wrap_s;
  logic          load_s;
  logic          blank_s;
  logic [3:0]    digit_s;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 shows a dash.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0010000;
      default: r = 7'b0111111;
    endcase
    return r;
  endfunction

  // Scan counters, snapshot capture and next pin values from the current slot position.
  always_comb begin
    wrap_s    = (div_cnt_q == CW'(SCAN_DIV - 1));
    load_s    = (div_cnt_q == '0) && (idx_q == 2'd0);
    div_cnt_d = wrap_s ? '0 : div_cnt_q + CW'(1);
    idx_d     = wrap_s ? idx_q + 2'd1 : idx_q;

    s_m1_d  = s_m1_q;
    s_m10_d = s_m10_q;
    s_h1_d  = s_h1_q;
    s_h10_d = s_h10_q;
    if (load_s) begin
      s_m1_d  = min1;
      s_m10_d = min10;
      s_h1_d  = hour1;
      s_h10_d = hour10;
    end
    frame_d = load_s;

    case (idx_q)
      2'd0:    digit_s = s_m1_q;
      2'd1:    digit_s = {1'b0, s_m10_q};
      2'd2:    digit_s = s_h1_q;
      default: digit_s = {2'b00, s_h10_q};
    endcase

    // The first cycle of every slot is dark so the previous digit cannot ghost.
    blank_s = (div_cnt_q == '0);
`ifdef CLOCK24_DISPLAY_LZB_EN
    if ((idx_q == 2'd3) && (s_h10_q == 2'd0)) begin
      blank_s = 1'b1;
    end
`endif

    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (!blank_s) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode(digit_s);
      dp_d  = (idx_q != 2'd2);
    end
  end

  // State and registered pins; reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt_q <= '0;
      idx_q     <= 2'd0;
      s_m1_q    <= 4'd0;
      s_m10_q   <= 3'd0;
      s_h1_q    <= 4'd0;
      s_h10_q   <= 2'd0;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
      dp_q      <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      s_m1_q    <= s_m1_d;
      s_m10_q   <= s_m10_d;
      s_h1_q    <= s_h1_d;
      s_h10_q   <= s_h10_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      frame_q   <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_clock24_display.sv
// Self-checking bench for clock24_display: directed scenarios with literal expectations plus
// randomized inputs/resets checked every cycle against a position-in-frame reference model.
module tb_clock24_display;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] min1;
  logic [2:0] min10;
  logic [3:0] hour1;
  logic [1:0] hour10;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

`ifdef CLOCK24_DISPLAY_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  clock24_display #(.SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset),
    .min1(min1), .min10(min10), .hour1(hour1), .hour10(hour10),
    .an(an), .seg(seg), .dp(dp), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_time(input int h10, input int h1, input int m10, input int m1);
    hour10 = 2'(h10); hour1 = 4'(h1); min10 = 3'(m10); min1 = 4'(m1);
  endtask

  // Reference model: output after an edge is a function of the edge count since reset release.
  initial begin
    int  n, p, k, o;
    bit  alive, started;
    int  snap [4];
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fr;
    alive = 0; started = 0; n = 0;
    forever begin
      @(posedge clk);
      if (reset === 1'b0) begin
        alive = 0; started = 1;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fr = 1'b0;
      end else if (started) begin
        n = alive ? n + 1 : 0;
        alive = 1;
        p = n % (4 * SD);
        k = p / SD;
        o = p % SD;
        if (p == 0) begin
          snap[0] = int'(min1); snap[1] = int'(min10);
          snap[2] = int'(hour1); snap[3] = int'(hour10);
        end
        e_fr = (p == 0);
        if (o == 0 || (LZB && k == 3 && snap[3] == 0)) begin
          e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
          e_an  = 4'(15 - (1 << k));
          e_seg = SEG_TAB[snap[k]];
          e_dp  = (k == 2) ? 1'b0 : 1'b1;
        end
      end
      #1;
      if (started) begin
        chk("model_an", 32'(an), 32'(e_an));
        chk("model_seg", 32'(seg), 32'(e_seg));
        chk("model_dp", 32'(dp), 32'(e_dp));
        chk("model_frame", 32'(frame), 32'(e_fr));
      end
    end
  end

  initial begin
    logic [3:0] an_exp [16];
    logic [6:0] seg_exp [4];
    an_exp  = '{4'hF,4'hE,4'hE,4'hE,4'hF,4'hD,4'hD,4'hD,4'hF,4'hB,4'hB,4'hB,4'hF,4'h7,4'h7,4'h7};
    seg_exp = '{7'b0010000, 7'b0010010, 7'b0110000, 7'b0100100};

    reset = 1'b0;
    set_time(2, 3, 5, 9);
    repeat (2) step();
    reset = 1'b1;
    repeat (6) step();

    // Reset held for 3 cycles mid-frame.
    reset = 1'b0;
    repeat (3) step();
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_frame", 32'(frame), 32'h0);
    reset = 1'b1;

    // Full frame of 23:59 starting at E0.
    for (int i = 0; i < 16; i++) begin
      step();
      chk("frame23_an", 32'(an), 32'(an_exp[i]));
      chk("frame23_frame", 32'(frame), (i == 0) ? 32'h1 : 32'h0);
      if (i % SD != 0) begin
        chk("frame23_seg", 32'(seg), 32'(seg_exp[i / SD]));
        chk("frame23_dp", 32'(dp), (i / SD == 2) ? 32'h0 : 32'h1);
      end
    end

    // Coherency: 12:34 snapshotted, 12:35 arrives during slot 2.
    set_time(1, 2, 3, 4);
    step();
    chk("coh_frame", 32'(frame), 32'h1);
    step();
    chk("coh_seg4", 32'(seg), 32'h19);
    repeat (8) step();
    set_time(1, 2, 3, 5);
    repeat (4) step();
    chk("coh_an3", 32'(an), 32'h7);
    chk("coh_seg1", 32'(seg), 32'h79);
    repeat (3) step();
    chk("coh_frame2", 32'(frame), 32'h1);
    step();
    chk("coh_seg5", 32'(seg), 32'h12);

    // Invalid BCD on min1.
    min1 = 4'hC;
    repeat (16) step();
    chk("bad_an", 32'(an), 32'hE);
    chk("bad_seg", 32'(seg), 32'h3F);

    // Leading zero, 09:41, inspected at slot 3 offset 1.
    set_time(0, 9, 4, 1);
    repeat (28) step();
    chk("lz_an", 32'(an), LZB ? 32'hF : 32'h7);
    chk("lz_seg", 32'(seg), LZB ? 32'h7F : 32'h40);

    // One-cycle reset during slot 2.
    repeat (12) step();
    chk("mid_slot2_an", 32'(an), 32'hB);
    reset = 1'b0;
    step();
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_frame", 32'(frame), 32'h0);
    reset = 1'b1;
    step();
    chk("mid_e0_frame", 32'(frame), 32'h1);
    chk("mid_e0_an", 32'(an), 32'hF);
    step();
    chk("mid_e1_an", 32'(an), 32'hE);
    chk("mid_e1_seg", 32'(seg), 32'h79);

    // Randomized inputs and occasional reset pulses, checked by the model process.
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 7) == 0) begin
        set_time(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      end
      reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
    end
    reset = 1'b1;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
